// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    SHR  = 2'd0,
    SHRA = 2'd1,
    SHL  = 2'd2,
    SHC  = 2'd3
  } shift_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_OPND = 3'd1,
    LD_CNT  = 3'd2,
    SHIFT   = 3'd3,
    WB      = 3'd4
  } shseq_state_t;

  // Datapath strobes that depend on state alone.
  typedef struct packed {
    logic done;
    logic rb_out;
    logic opnd_ld;
    logic imm_out;
    logic rc_out;
    logic cnt_ld;
    logic res_out;
    logic ra_in;
  } shseq_strb_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Control-unit handshake and datapath strobe bundle between the shift sequencer and its parent.
interface shift_sequencer_if
  import shift_pkg::*;
#(
  parameter int unsigned cw = CW
) ();

  logic            start;
  shift_op_t       op;
  logic [cw-1:0]   imm_count;
  logic            busy;
  logic            done;
  logic            rb_out;
  logic            opnd_ld;
  logic            imm_out;
  logic            rc_out;
  logic            cnt_ld;
  logic            cnt_decr;
  logic            cnt_zero;
  logic            shift_en;
  shift_op_t       shift_op;
  logic            res_out;
  logic            ra_in;

  modport master (
    input  start, op, imm_count, cnt_zero,
    output busy, done, rb_out, opnd_ld, imm_out, rc_out,
           cnt_ld, cnt_decr, shift_en, shift_op, res_out, ra_in
  );

  modport slave (
    output start, op, imm_count, cnt_zero,
    input  busy, done, rb_out, opnd_ld, imm_out, rc_out,
           cnt_ld, cnt_decr, shift_en, shift_op, res_out, ra_in
  );

endinterface

// File: rtl/shift_sequencer.sv
// Sequences one shr/shra/shl/shc instruction: operand load, count load,
// one shifter step per count, then result write-back.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned w  = 32,
  parameter int unsigned cw = CW
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.master sif
);

  if (cw != $clog2(w)) begin : g_cw_check
    $error("shift_sequencer: cw must equal log2(w)");
  end

  shseq_state_t  state_q, state_d;
  shift_op_t     op_q, op_d;
  logic [cw-1:0] count_q, count_d;
  shseq_strb_t   strb_q, strb_d;
  logic          busy_q, busy_d;
  logic          shift_ph_q, shift_ph_d;

  // State and registered strobes; async reset abandons any shift in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= SHR;
      count_q    <= '0;
      strb_q     <= '0;
      busy_q     <= 1'b0;
      shift_ph_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      strb_q     <= strb_d;
      busy_q     <= busy_d;
      shift_ph_q <= shift_ph_d;
    end
  end

  // Next state, plus strobes decoded from the state being entered so they leave a flop.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    count_d    = count_q;
    strb_d     = '0;
    busy_d     = 1'b0;
    shift_ph_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sif.start) begin
          op_d    = sif.op;
          count_d = sif.imm_count;
          state_d = LD_OPND;
        end
      end
      LD_OPND: state_d = LD_CNT;
      LD_CNT:  state_d = SHIFT;
      SHIFT: begin
        if (sif.cnt_zero) begin
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      LD_OPND: begin
        strb_d.rb_out  = 1'b1;
        strb_d.opnd_ld = 1'b1;
      end
      LD_CNT: begin
        // A zero c3 field means the count comes from R[c].
        strb_d.cnt_ld  = 1'b1;
        strb_d.imm_out = (count_q != '0);
        strb_d.rc_out  = (count_q == '0);
      end
      WB: begin
        strb_d.res_out = 1'b1;
        strb_d.ra_in   = 1'b1;
        strb_d.done    = 1'b1;
      end
      default: begin
        strb_d = '0;
      end
    endcase

    busy_d     = (state_d != IDLE);
    shift_ph_d = (state_d == SHIFT);
  end

  assign sif.busy     = busy_q;
  assign sif.done     = strb_q.done;
  assign sif.rb_out   = strb_q.rb_out;
  assign sif.opnd_ld  = strb_q.opnd_ld;
  assign sif.imm_out  = strb_q.imm_out;
  assign sif.rc_out   = strb_q.rc_out;
  assign sif.cnt_ld   = strb_q.cnt_ld;
  assign sif.res_out  = strb_q.res_out;
  assign sif.ra_in    = strb_q.ra_in;
  assign sif.shift_op = op_q;

  // cnt_zero is the counter's registered flag, so stepping stays flop-to-flop.
  assign sif.shift_en = shift_ph_q & ~sif.cnt_zero;
  assign sif.cnt_decr = shift_ph_q & ~sif.cnt_zero;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the shift counter and bus, and checks every
// cycle against a cycle-offset model of the instruction timeline.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_sequencer_if #(.cw(CW)) sif ();

  shift_sequencer #(.w(W), .cw(CW)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  // Surrounding datapath: bus source select and the shift-count counter.
  logic [W-1:0]  rc_val = '0;
  logic [CW-1:0] ir_c3  = '0;
  logic [CW-1:0] ctr;
  logic [W-1:0]  bus;

  always_comb begin
    bus = '0;
    if (sif.imm_out)     bus = W'(ir_c3);
    else if (sif.rc_out) bus = rc_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              ctr <= '0;
    else if (sif.cnt_ld)   ctr <= bus[CW-1:0];
    else if (sif.cnt_decr) ctr <= ctr - 1'b1;
  end

  assign sif.cnt_zero = (ctr == '0);

  // Timeline model: an accepted start at cycle t0 with count n defines every later cycle.
  int        cyc     = 0;
  int        t0      = 0;
  int        n_exp   = 0;
  bit        active  = 1'b0;
  bit        imm_sel = 1'b0;
  shift_op_t op_exp  = SHR;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active = 1'b0;
      op_exp = SHR;
    end else begin
      if (active && (cyc - t0) == 4 + n_exp) begin
        active = 1'b0;
      end else if (!active && sif.start) begin
        active  = 1'b1;
        t0      = cyc;
        op_exp  = sif.op;
        imm_sel = (sif.imm_count != '0);
        n_exp   = imm_sel ? int'(sif.imm_count) : int'(rc_val % W);
      end
      cyc++;
    end
  end

  function automatic logic [12:0] exp_vec(bit act, int k, int n, bit isel, shift_op_t o);
    logic b_e, d_e, rb_e, op_e, im_e, rc_e, ld_e, dc_e, sh_e, rs_e, ra_e;
    b_e = 0; d_e = 0; rb_e = 0; op_e = 0; im_e = 0; rc_e = 0;
    ld_e = 0; dc_e = 0; sh_e = 0; rs_e = 0; ra_e = 0;
    if (act) begin
      b_e = 1;
      if (k == 1) begin rb_e = 1; op_e = 1; end
      if (k == 2) begin ld_e = 1; im_e = isel; rc_e = !isel; end
      if (k >= 3 && k <= 2 + n) begin sh_e = 1; dc_e = 1; end
      if (k == 4 + n) begin rs_e = 1; ra_e = 1; d_e = 1; end
    end
    return {b_e, d_e, rb_e, op_e, im_e, rc_e, ld_e, dc_e, sh_e, rs_e, ra_e, 2'(o)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {sif.busy, sif.done, sif.rb_out, sif.opnd_ld, sif.imm_out, sif.rc_out,
            sif.cnt_ld, sif.cnt_decr, sif.shift_en, sif.res_out, sif.ra_in, 2'(sif.shift_op)};
  endfunction

  int checks = 0;
  int errors = 0;
  int sh_cnt = 0, done_cnt = 0, ra_cnt = 0, rc_cnt = 0, imm_cnt = 0, done_k = -1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic compare_loop();
    logic [12:0] a_v, e_v;
    forever begin
      @(negedge clk);
      a_v = dut_vec();
      e_v = exp_vec(active, cyc - t0, n_exp, imm_sel, op_exp);
      checks++;
      if (a_v !== e_v) begin
        errors++;
        $display("FAIL cycle_outputs @%0t: got %013b, expected %013b", $time, a_v, e_v);
      end
      chk("one_bus_driver", int'($countones({sif.rb_out, sif.imm_out, sif.rc_out, sif.res_out})) <= 1, 1);
      chk("busy_vs_state", int'(sif.busy), int'(dut.state_q != IDLE));
      if (sif.shift_en) sh_cnt++;
      if (sif.ra_in)    ra_cnt++;
      if (sif.rc_out)   rc_cnt++;
      if (sif.imm_out)  imm_cnt++;
      if (sif.done) begin
        done_cnt++;
        done_k = cyc - t0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input shift_op_t o, input int unsigned c3, input logic [W-1:0] rc);
    sif.op        = o;
    sif.imm_count = CW'(c3);
    ir_c3         = CW'(c3);
    rc_val        = rc;
    sif.start     = 1'b1;
    tick();
    sif.start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit leave);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (sif.done) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, expected done within 80 cycles", name);
    end
    if (leave) tick();
  endtask

  task automatic run_op(input string name, input shift_op_t o, input int unsigned c3,
                        input logic [W-1:0] rc, input int sh_req, input int k_req);
    int sh0, ra0, d0;
    sh0 = sh_cnt; ra0 = ra_cnt; d0 = done_cnt;
    launch(o, c3, rc);
    wait_done(name, 1'b1);
    chk({name, "_shifts"}, sh_cnt - sh0, sh_req);
    chk({name, "_done_cycle"}, done_k, k_req);
    chk({name, "_ra_pulses"}, ra_cnt - ra0, 1);
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic run_tests();
    int rc0, im0, sh0, ra0, d0, t0_a;

    sif.start     = 1'b0;
    sif.op        = SHR;
    sif.imm_count = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", int'(dut_vec()), 0);
    chk("reset_busy", int'(sif.busy), 0);
    rst = 1'b1;

    im0 = imm_cnt;
    run_op("shl_imm5", SHL, 5, 32'd0, 5, 9);
    chk("shl_imm5_imm_out", imm_cnt - im0, 1);

    rc0 = rc_cnt; im0 = imm_cnt;
    run_op("shc_rc3", SHC, 0, 32'd3, 3, 7);
    chk("shc_rc3_rc_out", rc_cnt - rc0, 1);
    chk("shc_rc3_no_imm_out", imm_cnt - im0, 0);

    run_op("shr_rc32", SHR, 0, 32'd32, 0, 4);
    run_op("shra_rc37", SHRA, 0, 32'd37, 5, 9);

    // start with a different op mid-shift must be ignored
    sh0 = sh_cnt; d0 = done_cnt;
    launch(SHL, 4, 32'd0);
    repeat (3) tick();
    sif.start = 1'b1; sif.op = SHR; sif.imm_count = CW'(7);
    tick();
    sif.start = 1'b0;
    chk("ignore_shift_op_held", int'(sif.shift_op), 2);
    wait_done("ignore", 1'b1);
    chk("ignore_shifts", sh_cnt - sh0, 4);
    chk("ignore_done_pulses", done_cnt - d0, 1);
    chk("ignore_shift_op_after", int'(sif.shift_op), 2);

    // async reset in the third SHIFT cycle
    ra0 = ra_cnt; d0 = done_cnt;
    launch(SHR, 6, 32'd0);
    repeat (4) tick();
    #1 rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'(dut_vec()), 0);
    repeat (2) tick();
    rst = 1'b1;
    chk("async_reset_no_ra", ra_cnt - ra0, 0);
    chk("async_reset_no_done", done_cnt - d0, 0);
    run_op("after_reset", SHRA, 2, 32'd0, 2, 6);

    // back-to-back: counts 2 then 1
    sh0 = sh_cnt; d0 = done_cnt;
    launch(SHL, 2, 32'd0);
    t0_a = t0;
    wait_done("b2b_first", 1'b0);
    sif.op = SHR; sif.imm_count = CW'(1); ir_c3 = CW'(1);
    sif.start = 1'b1;
    tick();
    tick();
    sif.start = 1'b0;
    chk("b2b_accept_gap", t0 - t0_a, 7);
    chk("b2b_second_busy", int'(sif.busy), 1);
    wait_done("b2b_second", 1'b1);
    chk("b2b_shifts", sh_cnt - sh0, 3);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("b2b_second_done_cycle", done_k, 5);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    fork
      compare_loop();
      run_tests();
    join
  end

endmodule
